// File: rtl/gb_pkg.sv
// Shared definitions for the bus cycle controller: default bus widths,
// wait counter width and the T-state encoding seen on t_cycle.
package gb_pkg;

  localparam int unsigned ADDR_SIZE_DEF = 16;
  localparam int unsigned DATA_SIZE_DEF = 8;
  localparam int unsigned WAIT_CNT_W    = 8;

  typedef enum logic [1:0] {
    T0 = 2'b00,
    T1 = 2'b01,
    T2 = 2'b10,
    T3 = 2'b11
  } tstate_e;

endpackage

// File: rtl/bus_cycle_ctrl_tcycle_counter.sv
// T-state sequencer: free-running T0..T3 with a T2 stall while memory
// is busy, an 8-bit wait counter and a sticky timeout flag.
module tcycle_counter
  import gb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    busy_i,
  input  logic    mem_wait_i,
  output tstate_e state_o,
  output logic    leave_t2_o,
  output logic    timeout_o
);

  localparam logic [WAIT_CNT_W-1:0] MaxWait = WAIT_CNT_W'(MAX_WAIT);

  tstate_e                state_q, state_d;
  logic [WAIT_CNT_W-1:0]  wait_q, wait_d;
  logic                   timeout_q, timeout_d;
  logic                   leaveT2;

  // State, wait counter and sticky timeout registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= T0;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  // Advance one T-state per clock; T2 stalls only for an active access
  // with memory busy, and a full wait counter forces the advance.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    leaveT2   = 1'b0;
    unique case (state_q)
      T0: state_d = T1;
      T1: state_d = T2;
      T2: begin
        if (busy_i && mem_wait_i) begin
          if (wait_q == MaxWait) begin
            timeout_d = 1'b1;
            state_d   = T3;
            leaveT2   = 1'b1;
            wait_d    = '0;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end else begin
          state_d = T3;
          leaveT2 = 1'b1;
          wait_d  = '0;
        end
      end
      T3: state_d = T0;
    endcase
  end

  assign state_o    = state_q;
  assign leave_t2_o = leaveT2;
  assign timeout_o  = timeout_q;

endmodule

// File: rtl/bus_cycle_ctrl.sv
// Memory-bus master: accepts one request per M-cycle at T0 and drives the
// address, strobes, write data and read-data return around the T-states.
module bus_cycle_ctrl
  import gb_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = ADDR_SIZE_DEF,
  parameter int unsigned DATA_SIZE = DATA_SIZE_DEF,
  parameter int unsigned MAX_WAIT  = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic                 req_we,
  input  logic                 req_fetch,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [DATA_SIZE-1:0] req_wdata,
  output logic                 req_ack,
  output logic [DATA_SIZE-1:0] rdata,
  output logic                 rdata_valid,
  input  logic [DATA_SIZE-1:0] mem_rdata,
  input  logic                 mem_wait,
  output logic [ADDR_SIZE-1:0] addr_bus,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 rd,
  output logic                 wr,
  output logic [1:0]           t_cycle,
  output logic                 m1t1,
  output logic                 bus_timeout
);

  tstate_e tState;
  logic    leaveT2;

  logic                 busy_q, busy_d;
  logic                 we_q, we_d;
  logic [DATA_SIZE-1:0] wdata_q, wdata_d;
  logic [ADDR_SIZE-1:0] addrBus_q, addrBus_d;
  logic [DATA_SIZE-1:0] dataOut_q, dataOut_d;
  logic                 rd_q, rd_d;
  logic                 wr_q, wr_d;
  logic                 reqAck_q, reqAck_d;
  logic                 m1t1_q, m1t1_d;
  logic [DATA_SIZE-1:0] rdata_q, rdata_d;
  logic                 rdataValid_q, rdataValid_d;

  tcycle_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_tcycle (
    .clk_i      (clk),
    .rst_i      (rst),
    .busy_i     (busy_q),
    .mem_wait_i (mem_wait),
    .state_o    (tState),
    .leave_t2_o (leaveT2),
    .timeout_o  (bus_timeout)
  );

  // Register all bus-side outputs and the latched request.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q       <= 1'b0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      addrBus_q    <= '0;
      dataOut_q    <= '0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      reqAck_q     <= 1'b0;
      m1t1_q       <= 1'b0;
      rdata_q      <= '0;
      rdataValid_q <= 1'b0;
    end else begin
      busy_q       <= busy_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      addrBus_q    <= addrBus_d;
      dataOut_q    <= dataOut_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      reqAck_q     <= reqAck_d;
      m1t1_q       <= m1t1_d;
      rdata_q      <= rdata_d;
      rdataValid_q <= rdataValid_d;
    end
  end

  // Decide what the next T-state shows, keyed on the state being left:
  // T3 leads into T0 (accept), T0 into T1 (write data), T2 into T3 (capture).
  always_comb begin
    busy_d       = busy_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    addrBus_d    = addrBus_q;
    dataOut_d    = dataOut_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    reqAck_d     = 1'b0;
    m1t1_d       = 1'b0;
    rdata_d      = rdata_q;
    rdataValid_d = 1'b0;
    unique case (tState)
      T3: begin
        busy_d = req;
        rd_d   = req & ~req_we;
        wr_d   = 1'b0;
        if (req) begin
          we_d      = req_we;
          wdata_d   = req_wdata;
          addrBus_d = req_addr;
          reqAck_d  = 1'b1;
          m1t1_d    = req_fetch & ~req_we;
        end
      end
      T0: begin
        if (busy_q && we_q) begin
          wr_d      = 1'b1;
          dataOut_d = wdata_q;
        end
      end
      T1: begin
      end
      T2: begin
        if (leaveT2) begin
          rd_d = 1'b0;
          wr_d = 1'b0;
          if (busy_q && !we_q) begin
            rdata_d      = mem_rdata;
            rdataValid_d = 1'b1;
          end
        end
      end
    endcase
  end

  assign req_ack     = reqAck_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdataValid_q;
  assign addr_bus    = addrBus_q;
  assign data_out    = dataOut_q;
  assign rd          = rd_q;
  assign wr          = wr_q;
  assign t_cycle     = tState;
  assign m1t1        = m1t1_q;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Bench for bus_cycle_ctrl: plays both core and memory, describing each
// M-cycle as a transaction and predicting every clock of it from the
// length of its wait-state stretch.
module tb_bus_cycle_ctrl;
  import gb_pkg::*;

  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, req_we, req_fetch;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        req_ack;
  logic [7:0]  rdata;
  logic        rdata_valid;
  logic [7:0]  mem_rdata;
  logic        mem_wait;
  logic [15:0] addr_bus;
  logic [7:0]  data_out;
  logic        rd, wr;
  logic [1:0]  t_cycle;
  logic        m1t1;
  logic        bus_timeout;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          active;
    bit          we;
    bit          fetch;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rbyte;
    int          nwait;
    int          raise;
    int          abortAt;
  } mc_t;

  mc_t plan[$];

  logic [15:0] expAddr;
  logic [7:0]  expDout;
  logic [7:0]  expRdata;
  bit          expTimeout;

  bus_cycle_ctrl #(
    .ADDR_SIZE (16),
    .DATA_SIZE (8),
    .MAX_WAIT  (MAXW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_we      (req_we),
    .req_fetch   (req_fetch),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_ack     (req_ack),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .mem_rdata   (mem_rdata),
    .mem_wait    (mem_wait),
    .addr_bus    (addr_bus),
    .data_out    (data_out),
    .rd          (rd),
    .wr          (wr),
    .t_cycle     (t_cycle),
    .m1t1        (m1t1),
    .bus_timeout (bus_timeout)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, wanted %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic mc_t mk(input bit active, input bit we, input bit fetch,
                             input logic [15:0] addr, input logic [7:0] wdata,
                             input logic [7:0] rbyte, input int nwait,
                             input int raise, input int abortAt);
    mc_t m;
    m.active  = active;
    m.we      = we;
    m.fetch   = fetch;
    m.addr    = addr;
    m.wdata   = wdata;
    m.rbyte   = rbyte;
    m.nwait   = nwait;
    m.raise   = raise;
    m.abortAt = abortAt;
    return m;
  endfunction

  function automatic mc_t mkRandom(input int maxWaitReq);
    return mk(($urandom % 4) != 0, 1'($urandom), 1'($urandom), 16'($urandom),
              8'($urandom), 8'($urandom), int'($urandom_range(0, maxWaitReq)),
              int'($urandom_range(0, 3)), -1);
  endfunction

  // Run one M-cycle: check every clock of it on the falling edge, then
  // drive memory and the next request for the coming rising edge.
  task automatic applyStimulus(input mc_t cur, input mc_t nxt);
    int s, len, tExp;
    bit tmo;
    s   = cur.active ? ((cur.nwait < MAXW) ? cur.nwait : MAXW) : 0;
    len = 4 + s;
    tmo = cur.active && (cur.nwait > MAXW);
    for (int j = 0; j < len; j++) begin
      @(negedge clk);
      if (cur.active && j == 0) expAddr = cur.addr;
      if (cur.active && cur.we && j == 1) expDout = cur.wdata;
      if (cur.active && !cur.we && j == len - 1) expRdata = cur.rbyte;
      if (tmo && j == len - 1) expTimeout = 1'b1;
      tExp = (j < 2) ? j : ((j < 3 + s) ? 2 : 3);
      checkOutput("t_cycle", 32'(t_cycle), 32'(tExp));
      checkOutput("req_ack", 32'(req_ack), 32'(cur.active && j == 0));
      checkOutput("m1t1", 32'(m1t1), 32'(cur.active && cur.fetch && !cur.we && j == 0));
      checkOutput("rd", 32'(rd), 32'(cur.active && !cur.we && j < len - 1));
      checkOutput("wr", 32'(wr), 32'(cur.active && cur.we && j >= 1 && j < len - 1));
      checkOutput("rdata_valid", 32'(rdata_valid), 32'(cur.active && !cur.we && j == len - 1));
      checkOutput("addr_bus", 32'(addr_bus), 32'(expAddr));
      checkOutput("data_out", 32'(data_out), 32'(expDout));
      checkOutput("rdata", 32'(rdata), 32'(expRdata));
      checkOutput("bus_timeout", 32'(bus_timeout), 32'(expTimeout));

      rst = 1'b0;
      if (cur.active && j >= 2 && j <= len - 2) mem_wait = ((j - 2) < cur.nwait);
      else mem_wait = 1'($urandom_range(0, 1));
      mem_rdata = (j == len - 2) ? cur.rbyte : 8'($urandom);
      if (nxt.active && j >= nxt.raise) begin
        req       = 1'b1;
        req_we    = nxt.we;
        req_fetch = nxt.fetch;
        req_addr  = nxt.addr;
        req_wdata = nxt.wdata;
      end else begin
        req       = 1'b0;
        req_we    = 1'($urandom);
        req_fetch = 1'($urandom);
        req_addr  = 16'($urandom);
        req_wdata = 8'($urandom);
      end
      if (j == cur.abortAt) begin
        rst = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    mc_t idle, nxt;
    idle = mk(1'b0, 1'b0, 1'b0, 16'h0, 8'h0, 8'h0, 0, 0, -1);

    rst = 1'b1; req = 1'b0; req_we = 1'b0; req_fetch = 1'b0;
    req_addr = '0; req_wdata = '0; mem_rdata = '0; mem_wait = 1'b0;
    expAddr = '0; expDout = '0; expRdata = '0; expTimeout = 1'b0;

    plan.push_back(idle);
    plan.push_back(mk(1, 0, 0, 16'hC000, 8'h00, 8'h3E, 0, 2, -1));
    plan.push_back(mk(1, 0, 1, 16'h0100, 8'h00, 8'h00, 0, 0, -1));
    plan.push_back(mk(1, 0, 1, 16'h0101, 8'h00, 8'hC3, 0, 0, -1));
    plan.push_back(mk(1, 0, 1, 16'h0102, 8'h00, 8'h50, 0, 0, -1));
    plan.push_back(mk(1, 1, 0, 16'hFF80, 8'hA5, 8'h00, 0, 1, -1));
    plan.push_back(mk(1, 0, 0, 16'h1234, 8'h00, 8'h5A, 3, 3, -1));
    plan.push_back(mk(1, 1, 0, 16'h2468, 8'h3C, 8'h00, MAXW, 0, -1));
    plan.push_back(idle);
    for (int i = 0; i < 60; i++) plan.push_back(mkRandom(MAXW));
    plan.push_back(mk(1, 0, 0, 16'h8000, 8'h00, 8'h77, MAXW + 5, 1, -1));
    plan.push_back(mk(1, 1, 0, 16'h4000, 8'h11, 8'h00, 0, 0, -1));
    plan.push_back(mk(1, 1, 0, 16'h2222, 8'h66, 8'h00, 0, 0, 1));
    plan.push_back(idle);
    plan.push_back(mk(1, 0, 0, 16'h0F0F, 8'h00, 8'h9C, 0, 0, -1));
    for (int i = 0; i < 60; i++) plan.push_back(mkRandom(MAXW + 3));
    plan.push_back(idle);

    repeat (3) @(posedge clk);

    for (int i = 0; i < plan.size(); i++) begin
      if (i + 1 < plan.size()) nxt = plan[i + 1];
      else nxt = idle;
      applyStimulus(plan[i], nxt);
      if (plan[i].abortAt >= 0) begin
        expAddr    = '0;
        expDout    = '0;
        expRdata   = '0;
        expTimeout = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_cycle_ctrl.md
Name: bus_cycle_ctrl

Overview:
- T-cycle sequencer and memory-bus master between the CPU core (decoder/register file) and the memory model.
- Each machine cycle (M-cycle) is 4 T-cycles. The block accepts one read, write or opcode-fetch request per M-cycle and drives addr_bus/rd/wr/data_out.
- Returns read data to the core and generates t_cycle and m1t1, which the decoder uses for pipelining and which benches sample.
- Supports memory wait states in T2, with a timeout error flag.

Parameters:
- ADDR_SIZE, 16, address bus width.
- DATA_SIZE, 8, data bus width.
- MAX_WAIT, 15, maximum consecutive wait-extended T2 cycles before timeout (1..255).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  1  core requests a bus access; held until req_ack.
- req_we  in  1  1 = write, 0 = read.
- req_fetch  in  1  read is an opcode fetch (M1); ignored when req_we=1.
- req_addr  in  ADDR_SIZE  access address.
- req_wdata  in  DATA_SIZE  write data.
- req_ack  out  1  one-clock pulse: request accepted this T0.
- rdata  out  DATA_SIZE  last read data, held until the next read completes.
- rdata_valid  out  1  one-clock pulse in T3 of a completed read.
- mem_rdata  in  DATA_SIZE  data from memory.
- mem_wait  in  1  memory not ready; extends T2.
- addr_bus  out  ADDR_SIZE  memory address.
- data_out  out  DATA_SIZE  write data to memory.
- rd  out  1  read strobe.
- wr  out  1  write strobe.
- t_cycle  out  2  current T-state, 0..3.
- m1t1  out  1  high during T0 of an opcode-fetch M-cycle.
- bus_timeout  out  1  sticky error flag; cleared only by rst.

Behaviour:
- Reset: t_cycle=0, addr_bus=0, data_out=0, rd=0, wr=0, req_ack=0, rdata=0, rdata_valid=0, m1t1=0, bus_timeout=0, wait counter=0.
- Reset asserted mid-access aborts the access: strobes drop on the next edge and no rdata_valid is produced.
- t_cycle free-runs 0→1→2→3→0, one step per clk. The only exception is a stall in T2 (see wait states).
- T0 accept: if req=1 at the clk edge that enters T0:
  - latch addr, we, fetch and wdata;
  - pulse req_ack that T0 cycle.
- Request rising during T1..T3 is not accepted until the next T0. The core must hold req stable until ack.
- Idle M-cycle (no req at T0): rd=wr=0; addr_bus and data_out hold their previous values; m1t1=0.
- Read M-cycle:
  - addr_bus is valid T0..T3; rd=1 in T0, T1, T2 (including stall cycles) and 0 in T3.
  - mem_rdata is sampled on the edge leaving T2 (mem_wait=0) into rdata.
  - rdata_valid=1 for exactly the T3 clock.
- Fetch M-cycle: identical to read, plus m1t1=1 during T0 only.
- Write M-cycle:
  - addr_bus is valid T0..T3; data_out=wdata from T1 through T3.
  - wr=1 in T1 and T2 (including stalls) and 0 in T3.
  - rdata is unchanged and rdata_valid=0.
- Wait states:
  - In T2 of a read or write, mem_wait=1 holds t_cycle at 2 and keeps strobes asserted.
  - An 8-bit wait counter increments each stall cycle.
  - When mem_wait=0, the block advances to T3 and clears the counter.
  - mem_wait is ignored in T0, T1, T3 and in idle M-cycles.
- Timeout: if the counter reaches MAX_WAIT while mem_wait is still 1:
  - set bus_timeout;
  - force advance to T3, with rdata loaded from mem_rdata as-is and rdata_valid still pulsed.
- Back-to-back: a request held at the T0 following T3 is accepted with no bubble, giving continuous M-cycles.
- Width rules: addresses and data are passed unmodified; no arithmetic on the address.

Decomposition:
- Shared package (gb_pkg): ADDR_SIZE/DATA_SIZE defaults and T-state constants T0=2'b00, T1=2'b01, T2=2'b10, T3=2'b11.
- Sub-module: tcycle_counter (2-bit counter with stall input plus wait counter/timeout). Latch, strobe and rdata logic stay in bus_cycle_ctrl.

Test Plan:
- Read: req=1, we=0, addr=16'hC000, mem_rdata=8'h3E, no wait → req_ack at T0; rd=1 T0–T2; rdata=8'h3E with rdata_valid one clock in T3; m1t1=0.
- Fetch back-to-back: three fetches at 16'h0100..0102 returning 8'h00, 8'hC3, 8'h50 → m1t1 high in each T0, no idle cycle between them, rdata_valid every 4 clks with the correct bytes.
- Write: req_we=1, addr=16'hFF80, wdata=8'hA5 → wr=1 only T1–T2; data_out=8'hA5 T1–T3; rdata unchanged; no rdata_valid.
- Wait states: read with mem_wait=1 for 3 clocks in T2 → t_cycle stays at 2 for 4 clks; rd stays high; data captured after release; the M-cycle is 7 clks total; bus_timeout=0.
- Timeout: MAX_WAIT=4, mem_wait stuck at 1 → bus_timeout=1 after 4 stall clks; advance to T3; bus_timeout stays 1 until rst.
- Reset mid-cycle: rst=1 during T1 of a write → next clk t_cycle=0, wr=0, all outputs at reset values; a request pending after rst=0 is accepted at the first T0.
